// File: rtl/ohm_bcd_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ohm_bcd_decode_pkg
//  Brief    : Shared constants, FSM state type and fixed-point helpers for
//             the ADC-resistance to BCD decoder.
//  Revision : 1.0  initial release
// ============================================================================
package ohm_bcd_decode_pkg;

    // Magnitude code the front end reports for an open circuit (62.875 ohm)
    localparam logic [10:0] OPEN_CODE = 11'h7DC;
    // Fractional bits in the 6.5 fixed-point magnitude
    localparam int          FRAC_BITS = 5;
    // Nibble shown on every digit for an open circuit
    localparam logic [3:0]  BCD_BLANK = 4'hF;
    // Width of the binary value fed to the double-dabble converter
    localparam int          N_SHIFT   = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Negative readings clamp to zero; the ADC delivers an inverted magnitude
    function automatic logic [10:0] decode_mag(input logic [11:0] r);
        return r[11] ? 11'd0 : (r[10:0] ^ 11'h7FF);
    endfunction

    // Whole ohms times 100 plus rounded hundredths; hundredths max 97 so no carry
    function automatic logic [12:0] calc_val(input logic [10:0] mag);
        logic [12:0] frac_x;
        logic [12:0] hund;
        frac_x = 13'(mag[FRAC_BITS-1:0]) * 13'd100 + 13'(1 << (FRAC_BITS - 1));
        hund   = frac_x >> FRAC_BITS;
        return 13'(mag[10:FRAC_BITS]) * 13'd100 + hund;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ohm_bcd_decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : ohm_bcd_decode_if
//  Brief    : Sample-in / digits-out bundle of the resistance decoder.
//  Revision : 1.0  initial release
// ============================================================================
interface ohm_bcd_decode_if;

    logic        valid_in;
    logic [11:0] r_in;
    logic        valid_out;
    logic [15:0] digits;
    logic        open_ckt;
    logic        busy;

    modport master (
        output valid_in, r_in,
        input  valid_out, digits, open_ckt, busy
    );

    modport slave (
        input  valid_in, r_in,
        output valid_out, digits, open_ckt, busy
    );

endinterface
`default_nettype wire

// File: rtl/ohm_bcd_decode_bcd_dabble_step.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_dabble_step
//  Brief    : One double-dabble iteration: add 3 to every nibble >= 5, then
//             shift the 16-bit BCD word left by one taking in bit_i.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_dabble_step
    import ohm_bcd_decode_pkg::*;
(
    input  logic [15:0] bcd_i,
    input  logic        bit_i,
    output logic [15:0] bcd_o
);

    logic [15:0] adj_w;

    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign adj_w[gi*4 +: 4] = (bcd_i[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_i[gi*4 +: 4] + 4'd3) :
                                   bcd_i[gi*4 +: 4];
    end

    // Bit shifted out of the top nibble is always zero for values <= 6397
    assign bcd_o = 16'({adj_w, bit_i});

endmodule
`default_nettype wire

// File: rtl/ohm_bcd_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ohm_bcd_decode
//  Brief    : Converts a 12-bit ADC resistance sample into four BCD digits
//             (tens .. hundredths of an ohm) with an iterative double-dabble,
//             a one-deep latest-wins pending slot and an open-circuit flag.
//  Revision : 1.0  initial release
// ============================================================================
module ohm_bcd_decode
    import ohm_bcd_decode_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    ohm_bcd_decode_if.slave  bus
);

    localparam logic [3:0] LAST_CNT = 4'(N_SHIFT - 1);

    state_e      state_q,    state_d;
    logic        pend_vld_q, pend_vld_d;
    logic [11:0] pend_q,     pend_d;
    logic [10:0] mag_q,      mag_d;
    logic [12:0] bin_q,      bin_d;
    logic [15:0] bcd_q,      bcd_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        is_open_q,  is_open_d;
    logic [15:0] digits_q,   digits_d;
    logic        open_q,     open_d;
    logic        vout_q,     vout_d;

    logic [15:0] step_w;
    logic        launch_w;
    logic [11:0] launch_smp_w;
    logic [10:0] launch_mag_w;

    bcd_dabble_step u_step (
        .bcd_i (bcd_q),
        .bit_i (bin_q[12]),
        .bcd_o (step_w)
    );

    // Next-state, datapath and output-register updates for the conversion FSM
    always_comb begin
        state_d      = state_q;
        pend_vld_d   = pend_vld_q;
        pend_d       = pend_q;
        mag_d        = mag_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        is_open_d    = is_open_q;
        digits_d     = digits_q;
        open_d       = open_q;
        vout_d       = 1'b0;
        launch_w     = 1'b0;
        launch_smp_w = bus.r_in;
        launch_mag_w = 11'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    launch_w     = 1'b1;
                    launch_smp_w = bus.r_in;
                end
            end
            ST_LOAD: begin
                bin_d   = calc_val(mag_q);
                bcd_d   = 16'd0;
                cnt_d   = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d = step_w;
                bin_d = {bin_q[11:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                // Final shift: publish digits so they are valid during DONE
                if (cnt_q == LAST_CNT) begin
                    state_d   = ST_DONE;
                    is_open_d = 1'b0;
                    digits_d  = step_w;
                    open_d    = 1'b0;
                    vout_d    = 1'b1;
                end
            end
            ST_DONE: begin
                // Open-code results are registered as DONE is left, so the
                // strobe follows the sample by two cycles
                if (is_open_q) begin
                    digits_d = {4{BCD_BLANK}};
                    open_d   = 1'b1;
                    vout_d   = 1'b1;
                end
                pend_vld_d = 1'b0;
                if (bus.valid_in) begin
                    launch_w     = 1'b1;
                    launch_smp_w = bus.r_in;
                end else if (pend_vld_q) begin
                    launch_w     = 1'b1;
                    launch_smp_w = pend_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Samples arriving mid-conversion park in the pending slot, newest wins
        if (((state_q == ST_LOAD) || (state_q == ST_SHIFT)) && bus.valid_in) begin
            pend_vld_d = 1'b1;
            pend_d     = bus.r_in;
        end

        if (launch_w) begin
            launch_mag_w = decode_mag(launch_smp_w);
            if (launch_mag_w == OPEN_CODE) begin
                state_d   = ST_DONE;
                is_open_d = 1'b1;
            end else begin
                state_d   = ST_LOAD;
                is_open_d = 1'b0;
                mag_d     = launch_mag_w;
            end
        end
    end

    // State and datapath registers; reset drops any conversion and pending sample
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_vld_q <= 1'b0;
            pend_q     <= 12'd0;
            mag_q      <= 11'd0;
            bin_q      <= 13'd0;
            bcd_q      <= 16'd0;
            cnt_q      <= 4'd0;
            is_open_q  <= 1'b0;
            digits_q   <= 16'd0;
            open_q     <= 1'b0;
            vout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            mag_q      <= mag_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            is_open_q  <= is_open_d;
            digits_q   <= digits_d;
            open_q     <= open_d;
            vout_q     <= vout_d;
        end
    end

    assign bus.valid_out = vout_q;
    assign bus.digits    = digits_q;
    assign bus.open_ckt  = open_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ohm_bcd_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ohm_bcd_decode
//  Brief    : Self-checking bench for ohm_bcd_decode with a latency-aware
//             scoreboard of expected conversions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ohm_bcd_decode;

    logic clk = 1'b0;
    logic reset;

    ohm_bcd_decode_if bus ();

    ohm_bcd_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    // Reference: {open, digits} computed with plain integer arithmetic
    function automatic logic [16:0] model(input logic [11:0] r);
        int mag;
        int v;
        logic [15:0] d;
        if (r[11]) mag = 0;
        else       mag = int'(r[10:0] ^ 11'h7FF);
        if (mag == 'h7DC) return {1'b1, 16'hFFFF};
        v = (mag / 32) * 100 + ((mag % 32) * 100 + 16) / 32;
        d = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        return {1'b0, d};
    endfunction

    // Scoreboard: every valid_out pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus.valid_out) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_out digits=%h cyc=%0d required=no_pulse", bus.digits, cyc);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if (bus.digits !== mon_e.d) begin
                    errors++;
                    $display("FAIL sb_digits got=%h exp=%h", bus.digits, mon_e.d);
                end
                checks++;
                if (bus.open_ckt !== mon_e.o) begin
                    errors++;
                    $display("FAIL sb_open_ckt got=%b exp=%b", bus.open_ckt, mon_e.o);
                end
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL sb_latency got_cyc=%0d exp_cyc=%0d", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle valid_in strobe; c0 is the cycle index the strobe occupied
    task automatic drive(input logic [11:0] r, output int c0);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.r_in     = r;
        c0           = cyc;
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic push_exp(input logic [11:0] r, input int due);
        exp_t e;
        logic [16:0] m;
        m     = model(r);
        e.d   = m[15:0];
        e.o   = m[16];
        e.due = due;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bit ok;
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.r_in     = 12'h7DF;
        idle(2);
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out got=%b exp=0", bus.valid_out); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.digits !== 16'h0000) begin errors++; $display("FAIL rst_digits got=%h exp=0000", bus.digits); end
        checks++;
        if (bus.open_ckt !== 1'b0) begin errors++; $display("FAIL rst_open_ckt got=%b exp=0", bus.open_ckt); end
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        idle(1);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_ignored_valid busy got=%b exp=0", bus.busy); end
        ok = 1'b1;
    endtask

    task automatic test_numeric;
        logic [11:0] vals [4];
        logic [16:0] m;
        int c0;
        bit ok;
        vals[0] = 12'h7DF;
        vals[1] = 12'h757;
        vals[2] = 12'h000;
        vals[3] = 12'h800;
        for (int i = 0; i < 4; i++) begin
            drive(vals[i], c0);
            push_exp(vals[i], c0 + 15);
            checks++;
            if (bus.busy !== 1'b1) begin errors++; $display("FAIL num_busy[%0d] got=%b exp=1", i, bus.busy); end
            wait_drain(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL num_timeout[%0d] pending=%0d exp=0", i, sbq.size()); sbq.delete(); end
            idle(3);
            m = model(vals[i]);
            checks++;
            if (bus.digits !== m[15:0] || bus.valid_out !== 1'b0) begin
                errors++;
                $display("FAIL num_hold[%0d] digits=%h vout=%b exp=%h/0", i, bus.digits, bus.valid_out, m[15:0]);
            end
        end
    endtask

    task automatic test_open;
        int c0;
        bit ok;
        drive(12'h023, c0);
        push_exp(12'h023, c0 + 2);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL open_timeout pending=%0d exp=0", sbq.size()); sbq.delete(); end
        idle(4);
        checks++;
        if (bus.open_ckt !== 1'b1 || bus.digits !== 16'hFFFF) begin
            errors++;
            $display("FAIL open_hold open=%b digits=%h exp=1/FFFF", bus.open_ckt, bus.digits);
        end
        drive(12'h7DF, c0);
        push_exp(12'h7DF, c0 + 15);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL open_clear_timeout pending=%0d exp=0", sbq.size()); sbq.delete(); end
        idle(1);
        checks++;
        if (bus.open_ckt !== 1'b0) begin errors++; $display("FAIL open_clear got=%b exp=0", bus.open_ckt); end
    endtask

    task automatic test_back_to_back;
        int c0;
        int c1;
        bit ok;
        drive(12'h7DF, c0);
        push_exp(12'h7DF, c0 + 15);
        idle(1);
        drive(12'h757, c1);
        idle(2);
        drive(12'h000, c1);
        // Latest pending sample starts after the first DONE: 15 + 15 cycles
        push_exp(12'h000, c0 + 30);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout pending=%0d exp=0", sbq.size()); sbq.delete(); end
        idle(20);
        checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h6397) begin
            errors++;
            $display("FAIL b2b_final busy=%b digits=%h exp=0/6397", bus.busy, bus.digits);
        end
    endtask

    task automatic test_reset_abort;
        int c0;
        int c1;
        bit ok;
        drive(12'h757, c0);
        idle(1);
        drive(12'h7DF, c1);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h0000 || bus.open_ckt !== 1'b0) begin
            errors++;
            $display("FAIL abort_state busy=%b digits=%h open=%b exp=0/0000/0", bus.busy, bus.digits, bus.open_ckt);
        end
        idle(25);
        checks++;
        if (bus.busy !== 1'b0 || bus.digits !== 16'h0000) begin
            errors++;
            $display("FAIL abort_quiet busy=%b digits=%h exp=0/0000", bus.busy, bus.digits);
        end
        drive(12'h757, c0);
        push_exp(12'h757, c0 + 15);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_next_timeout pending=%0d exp=0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_random;
        logic [11:0] r;
        logic [16:0] m;
        int c0;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            r = 12'($urandom_range(0, 4095));
            if (i == 0) r = 12'h023;
            m = model(r);
            drive(r, c0);
            push_exp(r, c0 + (m[16] ? 2 : 15));
            wait_drain(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rnd_timeout[%0d] r=%h pending=%0d exp=0", i, r, sbq.size()); sbq.delete(); end
            idle(2);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.r_in     = 12'h000;
        test_reset();
        test_numeric();
        test_open();
        test_back_to_back();
        test_reset_abort();
        test_random();
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ohm_bcd_decode.md
OHM_BCD_DECODE -- requirements
Module: ohm_bcd_decode

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, system clock; reset input 1, synchronous active-high reset.
REQ-002 valid_in  input  1  one-cycle strobe; r_in is valid.
REQ-003 r_in  input  12  resistance in ADC format: bit11 is sign, bits[10:0] are the inverted magnitude in 6.5 fixed-point ohms.
REQ-004 valid_out  output  1  one-cycle strobe; digit outputs updated.
REQ-005 digits  output  16  four BCD digits, [15:12] tens .. [3:0] hundredths of an ohm.
REQ-006 open_ckt  output  1  latched flag; last sample was the open-circuit code.
REQ-007 busy  output  1  high while a conversion is in progress.

Function
REQ-008 SHALL decode mag = r_in[10:0] XOR 11'h7FF; if r_in[11]=1, mag SHALL be 0.
REQ-009 mag == 11'h7DC (62.875 ohm code) SHALL set open_ckt=1 and digits=16'hFFFF, with no arithmetic; otherwise open_ckt=0.
REQ-010 Hundredths SHALL be computed as hund = (mag[4:0]*100 + 16) >> 5; range 0..97, so it never carries.
REQ-011 Binary value SHALL be val = mag[10:5]*100 + hund, 13 bits, range 0..6397.
REQ-012 Conversion SHALL be iterative double-dabble: one bit per cycle, 13 shift cycles; add-3 applies to any nibble >=5 before each shift.
REQ-013 FSM states: IDLE -> LOAD (1 cycle, compute val) -> SHIFT (13 cycles) -> DONE (1 cycle, update outputs, pulse valid_out) -> IDLE or LOAD.
REQ-014 Open-code path: IDLE -> DONE directly.
REQ-015 Latency: valid_out SHALL assert exactly 15 cycles after valid_in for numeric samples, and 2 cycles after for the open code.
REQ-016 busy SHALL be high in LOAD, SHIFT and DONE.
REQ-017 valid_in while busy SHALL capture r_in into a one-deep pending register; a later valid_in overwrites it (latest wins). No sample is ever blocked.
REQ-018 DONE with a pending sample SHALL go to LOAD (or to DONE for the open code) the next cycle and clear pending.
REQ-019 valid_in in the DONE cycle SHALL be treated as pending.
REQ-020 digits and open_ckt SHALL hold between valid_out pulses.
REQ-021 valid_out SHALL be high for exactly one cycle per conversion.

Reset
REQ-022 Reset values: FSM=IDLE, pending empty, valid_out=0, busy=0, digits=16'h0000, open_ckt=0.
REQ-023 Reset SHALL abort a conversion in progress with no valid_out, and discard any pending sample.
REQ-024 valid_in in the same cycle as reset SHALL be ignored.

Structure
REQ-025 A shared package SHALL hold: OPEN_CODE=11'h7DC, FRAC_BITS=5, BCD_BLANK=4'hF, N_SHIFT=13, and the FSM state enum.
REQ-026 One sub-module, bcd_dabble_step, SHALL implement combinational add-3 over four nibbles plus a 1-bit shift-in.

Verification
REQ-027 r_in=12'h7DF (1.00 ohm) -> digits=16'h0100, open_ckt=0, valid_out 15 cycles later.
REQ-028 r_in=12'h757 (mag 0x0A8, 5.25 ohm) -> digits=16'h0525; r_in=12'h000 (mag 0x7FF) -> digits=16'h6397; r_in=12'h800 (negative) -> 16'h0000.
REQ-029 r_in=12'h023 (open code) -> open_ckt=1, digits=16'hFFFF, valid_out 2 cycles later; a following 12'h7DF clears open_ckt.
REQ-030 Three valid_in during one conversion (0x7DF, 0x757, 0x000) -> exactly two valid_out pulses: first 0100, then 6397.
REQ-031 Reset asserted at SHIFT cycle 6 -> no valid_out, digits=0000, busy=0; the next sample converts normally with 15-cycle latency.
